// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini-SRC control sequencer: opcodes, IR field
// positions and the sequencer state encoding.
package mini_src_pkg;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;

   localparam logic [4:0] OPC_ADD  = 5'b00011;
   localparam logic [4:0] OPC_SUB  = 5'b00100;
   localparam logic [4:0] OPC_AND  = 5'b00101;
   localparam logic [4:0] OPC_OR   = 5'b00110;
   localparam logic [4:0] OPC_SHR  = 5'b00111;
   localparam logic [4:0] OPC_SHRA = 5'b01000;
   localparam logic [4:0] OPC_SHL  = 5'b01001;
   localparam logic [4:0] OPC_ROR  = 5'b01010;
   localparam logic [4:0] OPC_ROL  = 5'b01011;
   localparam logic [4:0] OPC_MUL  = 5'b01111;
   localparam logic [4:0] OPC_DIV  = 5'b10000;
   localparam logic [4:0] OPC_NEG  = 5'b10001;
   localparam logic [4:0] OPC_NOT  = 5'b10010;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_HALT  = 4'd8
   } state_t;

endpackage

// File: rtl/ir_decoder.sv
// Combinational IR field extraction: register one-hots and opcode class.
module ir_decoder
   import mini_src_pkg::*;
(
   input  logic [31:0] ir,
   output logic [4:0]  opcode,
   output logic [15:0] ra_oh,
   output logic [15:0] rb_oh,
   output logic [15:0] rc_oh,
   output logic        is_alu,
   output logic        is_muldiv,
   output logic        is_unary,
   output logic        is_halt
);

   // Low IR bits carry immediates/unused fields for these instruction classes.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[RC_LO-1:0];

   assign opcode = ir[OPC_HI:OPC_LO];
   assign ra_oh  = 16'd1 << ir[RA_HI:RA_LO];
   assign rb_oh  = 16'd1 << ir[RB_HI:RB_LO];
   assign rc_oh  = 16'd1 << ir[RC_HI:RC_LO];

   always_comb begin
      is_alu    = 1'b0;
      is_muldiv = 1'b0;
      is_unary  = 1'b0;
      is_halt   = 1'b0;
      case (opcode)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
         OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL: is_alu    = 1'b1;
         OPC_MUL, OPC_DIV:                    is_muldiv = 1'b1;
         OPC_NEG, OPC_NOT:                    is_unary  = 1'b1;
         OPC_HALT:                            is_halt   = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hard-wired Mini-SRC sequencer: fetch T0-T2, class-dependent execute T3-T6.
// Strobes are decoded from the state register and the latched IR only.
module control_unit
   import mini_src_pkg::*;
#(
   parameter int RESET_PC_HOLD = 0
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCin,
   output logic        PCout,
   output logic        IncPC,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Yin,
   output logic        ZLowin,
   output logic        ZHighin,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  OP,
   output logic        Run,
   output logic [3:0]  dbg_state
);

   state_t      state;
   logic [15:0] hold_cnt;
   logic [4:0]  opcode;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        is_alu, is_muldiv, is_unary, is_halt;

   ir_decoder u_dec (
      .ir        (IR),
      .opcode    (opcode),
      .ra_oh     (ra_oh),
      .rb_oh     (rb_oh),
      .rc_oh     (rc_oh),
      .is_alu    (is_alu),
      .is_muldiv (is_muldiv),
      .is_unary  (is_unary),
      .is_halt   (is_halt)
   );

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state    <= S_RESET;
         hold_cnt <= '0;
      end else begin
         case (state)
            S_RESET: begin
               if (hold_cnt == 16'(RESET_PC_HOLD)) state <= S_T0;
               else hold_cnt <= hold_cnt + 16'd1;
            end
            S_T0: state <= S_T1;
            S_T1: state <= S_T2;
            S_T2: state <= S_T3;
            // IR was loaded at the T2->T3 edge, so class decode is valid here on.
            S_T3: begin
               if (is_alu || is_muldiv || is_unary) state <= S_T4;
               else if (is_halt)                    state <= S_HALT;
               else                                 state <= S_T0;
            end
            S_T4:    state <= is_unary  ? S_T0 : S_T5;
            S_T5:    state <= is_muldiv ? S_T6 : S_T0;
            S_T6:    state <= S_T0;
            S_HALT:  state <= S_HALT;
            default: state <= S_RESET;
         endcase
      end
   end

   assign dbg_state = state;
   assign Run       = (state != S_RESET) && (state != S_HALT);

   always_comb begin
      Rin = '0;  Rout = '0;  OP = '0;
      PCin = 1'b0;  PCout = 1'b0;  IncPC = 1'b0;  IRin = 1'b0;
      MARin = 1'b0;  MDRin = 1'b0;  MDRout = 1'b0;  Read = 1'b0;
      Yin = 1'b0;  ZLowin = 1'b0;  ZHighin = 1'b0;  ZLowout = 1'b0;
      ZHighout = 1'b0;  HIin = 1'b0;  LOin = 1'b0;
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
         S_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (is_alu)         begin Rout = rb_oh; Yin = 1'b1; end
            else if (is_muldiv) begin Rout = ra_oh; Yin = 1'b1; end
            else if (is_unary)  begin Rout = rb_oh; OP = opcode; ZLowin = 1'b1; end
         end
         S_T4: begin
            if (is_alu)         begin Rout = rc_oh; OP = opcode; ZLowin = 1'b1; end
            else if (is_muldiv) begin Rout = rb_oh; OP = opcode; ZLowin = 1'b1; ZHighin = 1'b1; end
            else if (is_unary)  begin ZLowout = 1'b1; Rin = ra_oh; end
         end
         S_T5: begin
            if (is_alu)         begin ZLowout = 1'b1; Rin = ra_oh; end
            else if (is_muldiv) begin ZLowout = 1'b1; LOin = 1'b1; end
         end
         S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
         default: ;
      endcase
   end

endmodule
